// File: rtl/fp_pkg.sv
// fp_pkg: operand class encoding and flag bit positions shared by the fp multiplier
package fp_pkg;
    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;
    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UDF = 1;
    localparam int FLG_INX = 0;
endpackage

// File: rtl/fp_classify.sv
// fp_classify: splits an operand into fields, flushes subnormals to zero and decodes its class
module fp_classify import fp_pkg::*; #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0]     x,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] man,
    output fp_class_e        cls
);
    always_comb begin
        sign = x[W-1];
        exp  = x[W-2:MAN_W];
        man  = exp == '0 ? '0 : x[MAN_W-1:0];
        cls  = exp == '0 ? ZERO : exp != '1 ? NORM : man != '0 ? NAN : INF;
    end
endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage round-to-nearest-even floating-point multiplier with valid/ready flow control
module fp_mul_pipe import fp_pkg::*; #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic [3:0]   flags
);
    localparam int P_W = 2 * (MAN_W + 1);
    localparam int E_W = EXP_W + 2;
    localparam logic [E_W-1:0] BIAS  = E_W'((1 << (EXP_W - 1)) - 1);
    localparam logic [E_W-1:0] E_MAX = E_W'((1 << EXP_W) - 1);
    localparam logic [W-1:0]   QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        fp_class_e        cls;
    } fp_unp_t;
    fp_unp_t ua, ub;
    logic en, v1, v2, sg1, sg2, g2, st2;
    fp_class_e ca1, cb1, ca2, cb2;
    logic [E_W-1:0] e1, e2, e3;
    logic [P_W-1:0] p1;
    logic [P_W-2:0] nrm;
    logic [MAN_W-1:0] m2, mr;
    logic up, c, ovf, udf, nan, inv, inf, zero, sp;
    logic [W-1:0] y_n;
    logic [3:0] flags_n;
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .x(a), .sign(ua.sign), .exp(ua.exp), .man(ua.man), .cls(ua.cls)
    );
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .x(b), .sign(ub.sign), .exp(ub.exp), .man(ub.man), .cls(ub.cls)
    );
    assign en       = out_ready || !out_valid;
    assign in_ready = en;
    // Drop the hidden leading one; what remains is mantissa, guard, then sticky bits
    assign nrm = p1[P_W-1] ? p1[P_W-2:0] : {p1[P_W-3:0], 1'b0};
    always_comb begin
        up      = g2 && (st2 || m2[0]);
        {c, mr} = {1'b0, m2} + {{MAN_W{1'b0}}, up};
        e3      = e2 + {{(E_W-1){1'b0}}, c};
        ovf     = !e3[E_W-1] && e3 >= E_MAX;
        udf     = e3[E_W-1] || e3 == '0;
        nan     = ca2 == NAN || cb2 == NAN;
        inv     = (ca2 == INF && cb2 == ZERO) || (ca2 == ZERO && cb2 == INF);
        inf     = ca2 == INF || cb2 == INF;
        zero    = ca2 == ZERO || cb2 == ZERO;
        sp      = nan || inf || zero;
        y_n     = nan || inv ? QNAN :
                  inf || (!zero && ovf) ? {sg2, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                  zero || udf ? {sg2, {(W-1){1'b0}}} : {sg2, e3[EXP_W-1:0], mr};
        flags_n          = '0;
        flags_n[FLG_INV] = inv && !nan;
        flags_n[FLG_OVF] = !sp && ovf;
        flags_n[FLG_UDF] = !sp && udf;
        flags_n[FLG_INX] = !sp && (g2 || st2 || ovf || udf);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= '0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            y         <= y_n;
            flags     <= flags_n;
        end
    end
    always_ff @(posedge clk) begin
        if (en) begin
            sg1 <= ua.sign ^ ub.sign;
            ca1 <= ua.cls;
            cb1 <= ub.cls;
            e1  <= E_W'(ua.exp) + E_W'(ub.exp) - BIAS;
            p1  <= P_W'({1'b1, ua.man}) * P_W'({1'b1, ub.man});
            sg2 <= sg1;
            ca2 <= ca1;
            cb2 <= cb1;
            e2  <= e1 + {{(E_W-1){1'b0}}, p1[P_W-1]};
            m2  <= nrm[P_W-2 -: MAN_W];
            g2  <= nrm[MAN_W];
            st2 <= |nrm[MAN_W-1:0];
        end
    end
endmodule
